booth_ctrl: RTL

- Control-path FSM for the Booth multiplier, the stage directly upstream of the multiplier datapath.
- Sequences operand loading, the N add/subtract-and-shift iterations, and completion.
- Drives every datapath control strobe.
- Consumes the datapath status bits q0, qd and stop.
- The product is left in {A,Q} of the datapath, valid from the cycle done is asserted until the next accepted start.

---
 rtl/booth_ctrl_if.sv | 13 +
 rtl/booth_ctrl.sv | 45 ++++
 2 files changed

// File: rtl/booth_ctrl_if.sv
// booth_ctrl_if: handshake and strobe bundle between the Booth controller and its datapath/upstream.
interface booth_ctrl_if;
  logic start, q0, qd, stop;
  logic ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, ldcount, decount, busy, done;
  modport master (
    input  start, q0, qd, stop,
    output ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, ldcount, decount, busy, done
  );
  modport slave (
    output start, q0, qd, stop,
    input  ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, ldcount, decount, busy, done
  );
endinterface

// File: rtl/booth_ctrl.sv
// booth_ctrl: control FSM sequencing operand load, N Booth check/shift iterations and completion.
module booth_ctrl #(
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  booth_ctrl_if.master bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LDM   = 3'd1;
  localparam logic [2:0] LDQ   = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  if (N < 1) begin : g_n_check
    $error("booth_ctrl: N must be at least 1");
  end
  logic [2:0] state, nxt;
  logic chk;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE  ? (bus.start ? LDM : IDLE) :
          state == LDM   ? LDQ :
          state == LDQ   ? CHECK :
          state == CHECK ? SHIFT :
          state == SHIFT ? (bus.stop ? DONE : CHECK) : IDLE;
  end
  assign chk         = state == CHECK;
  // Booth recoding: 10 subtracts M, 01 adds M, 00/11 only shift
  assign bus.ldA     = chk & (bus.q0 ^ bus.qd);
  assign bus.addsub  = chk & ~bus.q0 & bus.qd;
  assign bus.decount = chk;
  assign bus.clrA    = state == LDM;
  assign bus.clrQ    = state == LDM;
  assign bus.ldM     = state == LDM;
  assign bus.ldcount = state == LDM;
  assign bus.ldQ     = state == LDQ;
  assign bus.clrff   = state == LDQ;
  assign bus.sftA    = state == SHIFT;
  assign bus.sftQ    = state == SHIFT;
  assign bus.done    = state == DONE;
  assign bus.busy    = state != IDLE && state != DONE;
endmodule
